// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// firebird7_in_gate1_tessent_data_mux_ctrl: IJTAG TDR driving gate1 data-mux override select/data with optional auto-release pulse
module firebird7_in_gate1_tessent_data_mux_ctrl #(
   parameter int WIDTH        = 3,
   parameter int PULSE_CYCLES = 16
) (
   input  logic             ijtag_tck,
   input  logic             ijtag_reset,
   input  logic             ijtag_sel,
   input  logic             ijtag_ce,
   input  logic             ijtag_se,
   input  logic             ijtag_ue,
   input  logic             ijtag_si,
   output logic             ijtag_so,
   input  logic [WIDTH-1:0] observe_data_in,
   output logic             ijtag_select,
   output logic [WIDTH-1:0] ijtag_data_out,
   output logic             pulse_active
);
   localparam int L  = WIDTH + 2;
   localparam int CW = $clog2(PULSE_CYCLES + 1);

   logic [L-1:0]     r_sr;
   logic             r_sel;
   logic             r_mode;
   logic [WIDTH-1:0] r_data;
   logic [CW-1:0]    r_cnt;
   logic             w_upd;

   assign w_upd = ijtag_sel & ijtag_ue;

   always_ff @(posedge ijtag_tck) begin
      if (!ijtag_reset) begin
         r_sr   <= '0;
         r_sel  <= 1'b0;
         r_mode <= 1'b0;
         r_data <= '0;
         r_cnt  <= '0;
      end else begin
         if (ijtag_sel & ijtag_ce)
            r_sr <= {observe_data_in, r_mode, r_sel};
         else if (ijtag_sel & ijtag_se)
            r_sr <= {ijtag_si, r_sr[L-1:1]};
         // update consumes the pre-edge sr and retriggers any running pulse
         if (w_upd) begin
            r_data <= r_sr[L-1:2];
            r_mode <= r_sr[1];
            r_sel  <= r_sr[0];
            r_cnt  <= (r_sr[0] & r_sr[1]) ? CW'(PULSE_CYCLES) : '0;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1))
               r_sel <= 1'b0;
         end
      end
   end

   assign ijtag_so       = r_sr[0];
   assign ijtag_select   = r_sel;
   assign ijtag_data_out = r_data;
   assign pulse_active   = (r_cnt != '0);
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// tb_firebird7_in_gate1_tessent_data_mux_ctrl: scoreboard bench, expectations packed as {select, data_out[2:0], pulse_active, so}
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
   logic [2:0] obs_in = 3'd0;
   logic       so, select, pa;
   logic [2:0] dout;
   logic [5:0] q[$];
   logic [5:0] e;
   logic [5:0] obs;
   int         n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   assign obs = {select, dout, pa, so};

   firebird7_in_gate1_tessent_data_mux_ctrl #(.WIDTH(3), .PULSE_CYCLES(4)) u_dut (
      .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_ce(ce),
      .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so),
      .observe_data_in(obs_in), .ijtag_select(select),
      .ijtag_data_out(dout), .pulse_active(pa)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift5(input logic [4:0] v);
      sel = 1'b1;
      for (int i = 0; i < 5; i++) begin
         se = 1'b1;
         si = v[i];
         tick();
      end
      se = 1'b0;
      si = 1'b0;
   endtask

   task automatic test_reset();
      q.push_back(6'b000000);
      tick();
      e = q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_init: got %b exp %b", obs, e); end
      rst_n = 1'b1;
      shift5({3'($urandom_range(7)), 2'b11});
      ue = 1'b1; tick(); ue = 1'b0;
      shift5(5'($urandom_range(31)));
      for (int i = 0; i < 3; i++) begin
         rst_n = (i != 0);
         se = (i == 0);
         si = 1'($urandom_range(1));
         q.push_back(6'b000000);
         tick();
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL reset_mid step%0d: got %b exp %b", i, obs, e); end
      end
      se = 1'b0;
   endtask

   task automatic test_level();
      shift5(5'b10101);
      ue = 1'b1;
      for (int i = 0; i < 100; i++) q.push_back(6'b110101);
      tick();
      ue = 1'b0;
      for (int i = 0; i < 100; i++) begin
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL level cyc%0d: got %b exp %b", i, obs, e); end
         tick();
      end
   endtask

   task automatic test_pulse();
      logic [5:0] ex [8] = '{6'b101111, 6'b101111, 6'b101111, 6'b101111,
                             6'b001101, 6'b001101, 6'b001101, 6'b001101};
      shift5(5'b01111);
      for (int i = 0; i < 8; i++) begin
         ue = (i == 0);
         q.push_back(ex[i]);
         tick();
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL pulse cyc%0d: got %b exp %b", i, obs, e); end
      end
      ue = 1'b0;
   endtask

   task automatic test_capture();
      logic [2:0] ctl [7] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b010};
      logic [5:0] ex [7]  = '{6'b111011, 6'b111011, 6'b111011, 6'b111011,
                              6'b011000, 6'b011001, 6'b011001};
      shift5(5'b11011);
      obs_in = 3'b110;
      for (int i = 0; i < 7; i++) begin
         {ce, se, ue} = ctl[i];
         si = 1'b0;
         q.push_back(ex[i]);
         tick();
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL capture step%0d: got %b exp %b", i, obs, e); end
      end
      {ce, se, ue} = 3'b000;
   endtask

   task automatic test_priority_gating();
      logic [5:0] ex [5] = '{6'b011000, 6'b011001, 6'b011000, 6'b011001, 6'b011000};
      obs_in = 3'b010;
      for (int i = 0; i < 5; i++) begin
         ce = (i == 0);
         se = 1'b1;
         si = (i == 0);
         q.push_back(ex[i]);
         tick();
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL priority step%0d: got %b exp %b", i, obs, e); end
      end
      {ce, se, si} = 3'b000;
      shift5(5'b11101);
      obs_in = 3'b000;
      for (int i = 0; i < 4; i++) begin
         sel = (i == 3);
         {ce, se, ue} = (i == 3) ? 3'b001 : 3'b111;
         q.push_back((i == 3) ? 6'b111101 : 6'b011001);
         tick();
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL gating step%0d: got %b exp %b", i, obs, e); end
      end
      {ce, se, ue} = 3'b000;
   endtask

   task automatic test_abort();
      logic [2:0] ctl [5] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b000};
      logic [5:0] ex [5]  = '{6'b101011, 6'b101011, 6'b101010, 6'b000000, 6'b000000};
      logic [5:0] ex2 [5] = '{6'b101011, 6'b101011, 6'b000000, 6'b000000, 6'b000000};
      shift5(5'b01011);
      for (int i = 0; i < 5; i++) begin
         {ce, se, ue} = ctl[i];
         si = 1'b0;
         q.push_back(ex[i]);
         tick();
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL abort_upd step%0d: got %b exp %b", i, obs, e); end
      end
      {ce, se, ue} = 3'b000;
      shift5(5'b01011);
      for (int i = 0; i < 5; i++) begin
         ue = (i == 0);
         rst_n = (i != 2);
         q.push_back(ex2[i]);
         tick();
         e = q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL abort_rst step%0d: got %b exp %b", i, obs, e); end
      end
      ue = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_level();
      test_pulse();
      test_capture();
      test_priority_gating();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
